// File: rtl/aes_scan_pkg.sv
// Shared definitions for the AES scan-chain controller: command opcodes,
// controller FSM states and opcode classification helpers.
package aes_scan_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_DUMP = 2'b01,
        OP_LOAD = 2'b10,
        OP_SWAP = 2'b11
    } scan_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } scan_state_e;

    // Ops that push host words into the chain.
    function automatic logic op_loads(input scan_op_e op);
        return (op == OP_LOAD) || (op == OP_SWAP);
    endfunction

    // Ops that return captured chain words to the host.
    function automatic logic op_dumps(input scan_op_e op);
        return (op == OP_DUMP) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/aes_scan_word_sr.sv
// Word-wide shift register: parallel load, shift left with LSB serial in,
// MSB serial out. Load takes priority over shift.
module aes_scan_word_sr #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    input  logic              serial_in,
    output logic              serial_out,
    output logic [WORD_W-1:0] q
);

    // NOTE: non-blocking assignments make every flop sample pre-edge values;
    // blocking ones would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (load)  q <= load_data;
        else if (shift) q <= {q[WORD_W-2:0], serial_in};
    end

    assign serial_out = q[WORD_W-1];

endmodule

// File: rtl/aes_scan_ctrl.sv
// Scan-chain master: serialises host words into an attached core's scan chain
// and deserialises the chain into host words (dump, load or swap).
module aes_scan_ctrl #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [WORD_W-1:0] din_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [WORD_W-1:0] dout_data,
    output logic              scan_enable,
    output logic              scan_ck_en,
    output logic              scan_input,
    input  logic              scan_output,
    output logic              busy,
    output logic              done
);
    import aes_scan_pkg::*;

    localparam int SC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ALL_BITS  = CNT_W'(CHAIN_LEN);
    localparam logic [SC_W-1:0]  WORD_LAST = SC_W'(WORD_W - 1);
    localparam logic [SC_W-1:0]  WORD_FULL = SC_W'(WORD_W);

    scan_state_e       state_q, state_d;
    scan_op_e          op_q;
    logic [CNT_W-1:0]  bits_done_q;
    logic [SC_W-1:0]   shift_cnt_q;
    logic              cmd_accept;
    logic              last_shift;
    logic              load_msb;
    logic              cap_msb_unused;
    logic [WORD_W-1:0] load_word_unused;
    logic [WORD_W-1:0] cap_word;

    assign cmd_accept = (state_q == S_IDLE) && cmd_valid;
    assign last_shift = (shift_cnt_q == WORD_LAST) || (bits_done_q == LAST_BIT);

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        scan_enable = 1'b0;
        scan_ck_en  = 1'b0;
        scan_input  = 1'b0;
        din_ready   = 1'b0;
        dout_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_d = (cmd_op == OP_NONE) ? S_DONE : S_ARM;
            end
            S_ARM: begin
                scan_enable = 1'b1;
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                scan_enable = 1'b1;
                if (op_loads(op_q)) begin
                    din_ready = din_valid;
                    if (din_valid) state_d = S_SHIFT;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scan_enable = 1'b1;
                scan_ck_en  = 1'b1;
                // Dump recirculates the tail so a full pass leaves the chain intact.
                scan_input  = op_loads(op_q) ? load_msb : scan_output;
                if (last_shift) begin
                    if (op_dumps(op_q))              state_d = S_DRAIN;
                    else if (bits_done_q == LAST_BIT) state_d = S_DONE;
                    else                              state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                scan_enable = 1'b1;
                dout_valid  = 1'b1;
                if (dout_ready)
                    state_d = (bits_done_q == ALL_BITS) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NONE;
            bits_done_q <= '0;
            shift_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_accept) begin
                op_q        <= scan_op_e'(cmd_op);
                bits_done_q <= '0;
            end
            if (state_q == S_FETCH) shift_cnt_q <= '0;
            if (scan_ck_en) begin
                bits_done_q <= bits_done_q + 1'b1;
                shift_cnt_q <= shift_cnt_q + 1'b1;
            end
        end
    end

    aes_scan_word_sr #(.WORD_W(WORD_W)) u_load_sr (
        .clk        (clk),
        .rst        (rst),
        .load       (din_valid && din_ready),
        .load_data  (din_data),
        .shift      (scan_ck_en),
        .serial_in  (1'b0),
        .serial_out (load_msb),
        .q          (load_word_unused)
    );

    aes_scan_word_sr #(.WORD_W(WORD_W)) u_cap_sr (
        .clk        (clk),
        .rst        (rst),
        .load       (cmd_accept),
        .load_data  ('0),
        .shift      (scan_ck_en),
        .serial_in  (scan_output),
        .serial_out (cap_msb_unused),
        .q          (cap_word)
    );

    // A short final word sits in the low bits; left-align it and zero-fill.
    assign dout_data = cap_word << (WORD_FULL - shift_cnt_q);

endmodule
